// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the MEM->WB skid stage
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_DEST_W = 4;

    typedef struct packed {
        logic                   wb_en;
        logic                   mem_r_en;
        logic [PIPE_DATA_W-1:0] alu_result;
        logic [PIPE_DATA_W-1:0] mem_read_value;
        logic [PIPE_DEST_W-1:0] dest;
    } pipe_payload_t;

    // Encoded as {head_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } pipe_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one payload register with load enable and async reset
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mem_wb_skid_reg.sv
// rtl/mem_wb_skid_reg.sv - MEM->WB boundary register as a 2-entry skid buffer
module mem_wb_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int DEST_W = PIPE_DEST_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_en_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] Mem_read_value_in,
    input  logic [DEST_W-1:0] Dest_in,
    input  logic              freeze,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_en,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] Mem_read_value,
    output logic [DEST_W-1:0] Dest,
    output logic [DATA_W-1:0] WB_value,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = 2 + 2 * DATA_W + DEST_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_e      state_q, state_d;
    logic             head_v, skid_v;
    logic             push, pop;
    logic             head_load, skid_load, head_from_skid;
    logic [PW-1:0]    in_payload, head_d, head_q, skid_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign {head_v, skid_v} = state_q;
    assign in_payload = {WB_en_in, MEM_R_en_in, ALU_result_in, Mem_read_value_in, Dest_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                    end else if (pop && !push) begin
                        state_d = EMPTY;
                    end
                end
                TWO:     if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready looks only at registered occupancy, never at out_ready.
    always_comb begin
        in_ready       = ~skid_v & ~freeze & ~flush;
        push           = in_valid & in_ready;
        pop            = head_v & out_ready & ~freeze & ~flush;
        head_from_skid = 1'b0;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: head_load = push;
            ONE: begin
                head_load = push & pop;
                skid_load = push & ~pop;
            end
            TWO: begin
                head_load      = pop;
                head_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign head_d = head_from_skid ? skid_q : in_payload;

    pipe_entry_reg #(.W(PW)) u_head (
        .clk    (clk),
        .rst    (rst),
        .load_i (head_load),
        .d_i    (head_d),
        .q_o    (head_q)
    );

    pipe_entry_reg #(.W(PW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .d_i    (in_payload),
        .q_o    (skid_q)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_v && !out_ready && !freeze && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid      = head_v;
    assign WB_en          = head_q[PW-1] & head_v;
    assign MEM_R_en       = head_q[PW-2];
    assign ALU_result     = head_q[DEST_W+DATA_W +: DATA_W];
    assign Mem_read_value = head_q[DEST_W +: DATA_W];
    assign Dest           = head_q[DEST_W-1:0];
    assign WB_value       = MEM_R_en ? Mem_read_value : ALU_result;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// tb/tb_mem_wb_skid_reg.sv - scoreboard bench for mem_wb_skid_reg
module tb_mem_wb_skid_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, WB_en_in = 1'b0, MEM_R_en_in = 1'b0;
    logic [31:0] ALU_result_in = '0, Mem_read_value_in = '0;
    logic [3:0]  Dest_in = '0;
    logic        freeze = 1'b0, flush = 1'b0, out_ready = 1'b0;

    logic        in_ready, out_valid, WB_en, MEM_R_en;
    logic [31:0] ALU_result, Mem_read_value, WB_value;
    logic [3:0]  Dest;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, WB_en2, MEM_R_en2;
    logic [31:0] ALU_result2, Mem_read_value2, WB_value2;
    logic [3:0]  Dest2;
    logic [1:0]  stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_payload_t mq[$];
    pipe_payload_t last_head;
    int            exp_cnt, exp_cnt2;

    always #5 clk = ~clk;

    mem_wb_skid_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in), .ALU_result_in(ALU_result_in),
        .Mem_read_value_in(Mem_read_value_in), .Dest_in(Dest_in), .freeze(freeze),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .WB_en(WB_en),
        .MEM_R_en(MEM_R_en), .ALU_result(ALU_result), .Mem_read_value(Mem_read_value),
        .Dest(Dest), .WB_value(WB_value), .stall_cnt(stall_cnt)
    );

    mem_wb_skid_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in), .ALU_result_in(ALU_result_in),
        .Mem_read_value_in(Mem_read_value_in), .Dest_in(Dest_in), .freeze(freeze),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .WB_en(WB_en2),
        .MEM_R_en(MEM_R_en2), .ALU_result(ALU_result2), .Mem_read_value(Mem_read_value2),
        .Dest(Dest2), .WB_value(WB_value2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_WB_en"}, WB_en, 0);
        check({tag, "_MEM_R_en"}, MEM_R_en, 0);
        check({tag, "_ALU_result"}, ALU_result, 0);
        check({tag, "_Mem_read_value"}, Mem_read_value, 0);
        check({tag, "_Dest"}, Dest, 0);
        check({tag, "_WB_value"}, WB_value, 0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
        check({tag, "_stall_cnt2"}, stall_cnt2, 0);
    endtask

    // Reference: a FIFO of at most two entries; outputs show its front.
    always @(negedge clk) begin
        pipe_payload_t hd, inp;
        logic          exp_ir;
        if (rst) begin
            check_outputs_zero("rst");
            mq.delete();
            last_head = '0;
            exp_cnt   = 0;
            exp_cnt2  = 0;
        end else begin
            exp_ir = (mq.size() < 2) && !freeze && !flush;
            hd = (mq.size() > 0) ? mq[0] : last_head;
            check("in_ready", in_ready, exp_ir);
            check("out_valid", out_valid, mq.size() > 0);
            check("WB_en", WB_en, hd.wb_en && (mq.size() > 0));
            check("MEM_R_en", MEM_R_en, hd.mem_r_en);
            check("ALU_result", ALU_result, hd.alu_result);
            check("Mem_read_value", Mem_read_value, hd.mem_read_value);
            check("Dest", Dest, hd.dest);
            check("WB_value", WB_value, hd.mem_r_en ? hd.mem_read_value : hd.alu_result);
            check("stall_cnt", stall_cnt, exp_cnt);
            check("stall_cnt_w2", stall_cnt2, exp_cnt2);
            check("out_valid_w2", out_valid2, out_valid);

            if (mq.size() > 0 && !out_ready && !freeze) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
            if (flush) begin
                mq.delete();
            end else if (!freeze) begin
                if (out_ready && mq.size() > 0) void'(mq.pop_front());
                if (in_valid && exp_ir) begin
                    inp = '{WB_en_in, MEM_R_en_in, ALU_result_in, Mem_read_value_in, Dest_in};
                    mq.push_back(inp);
                end
            end
            if (mq.size() > 0) last_head = mq[0];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] alu, input logic ordy);
        in_valid          = iv;
        WB_en_in          = 1'b1;
        MEM_R_en_in       = 1'b0;
        ALU_result_in     = alu;
        Mem_read_value_in = $urandom;
        Dest_in           = alu[3:0];
        out_ready         = ordy;
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 0; n < 8; n++) drive(1'b1, 32'h10 + n, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        drive(1'b1, 32'hA1, 1'b0);
        drive(1'b1, 32'hA2, 1'b0);
        repeat (3) drive(1'b0, 32'h0, 1'b0);
        repeat (3) drive(1'b0, 32'h0, 1'b1);

        in_valid = 1'b1; MEM_R_en_in = 1'b1; Mem_read_value_in = 32'hDEADBEEF;
        ALU_result_in = 32'h40; Dest_in = 4'h5; out_ready = 1'b1;
        step();
        MEM_R_en_in = 1'b0; ALU_result_in = 32'h44; Mem_read_value_in = 32'h12345678;
        step();
        drive(1'b0, 32'h0, 1'b1);

        drive(1'b1, 32'hB1, 1'b0);
        drive(1'b1, 32'hB2, 1'b0);
        flush = 1'b1;
        drive(1'b1, 32'hB3, 1'b1);
        flush = 1'b0;
        repeat (2) drive(1'b0, 32'h0, 1'b1);

        drive(1'b1, 32'hC1, 1'b0);
        freeze = 1'b1;
        repeat (3) drive(1'b1, 32'hC2, 1'b1);
        freeze = 1'b0;
        for (int n = 0; n < 4; n++) drive(1'b1, 32'hC2 + n, 1'b1);
        drive(1'b0, 32'h0, 1'b1);

        drive(1'b1, 32'hD1, 1'b0);
        drive(1'b1, 32'hD2, 1'b0);
        repeat (5) drive(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_rst");
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            in_valid          = $urandom_range(0, 3) != 0;
            WB_en_in          = $urandom_range(0, 1);
            MEM_R_en_in       = $urandom_range(0, 1);
            ALU_result_in     = $urandom;
            Mem_read_value_in = $urandom;
            Dest_in           = 4'($urandom);
            out_ready         = $urandom_range(0, 2) != 0;
            freeze            = $urandom_range(0, 9) == 0;
            flush             = $urandom_range(0, 19) == 0;
            step();
        end
        freeze = 1'b0; flush = 1'b0;
        repeat (4) drive(1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
